sync_capture_ctrl: RTL

Parametrised trigger and capture-window controller for the scope/LA acquisition path. It selects one of N_CH analog channels or the LA trigger input and detects a trigger event. Supported trigger modes are rising edge with hysteresis, falling edge with hysteresis, window-out and window-in, each with a glitch filter. It sequences pre-trigger fill, armed, post-trigger count and done, and reports Write_Ready and the trigger sample index to the MCU interface.

---
 rtl/sync_capture_ctrl_if.sv | 21 ++
 rtl/sync_capture_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sync_capture_ctrl_if.sv
// MCU-side handshake of the capture controller: the acquisition request
// (Start_Write) and the status/result returned to the MCU.
interface sync_capture_ctrl_if #(
    parameter int CNT_W = 18
);
    logic             Start_Write;
    logic             Write_Ready;
    logic             sync_state_out;
    logic [CNT_W-1:0] Trig_Pos;
    logic             Busy;

    modport master (
        output Start_Write,
        input  Write_Ready, sync_state_out, Trig_Pos, Busy
    );

    modport slave (
        input  Start_Write,
        output Write_Ready, sync_state_out, Trig_Pos, Busy
    );
endinterface

// File: rtl/sync_capture_ctrl.sv
// Trigger detection and capture-window sequencing (IDLE/PRETRIG/ARMED/POST/DONE).
// Optional auto-trigger timeout is built when SYNC_AUTO_TRIG_EN is defined.
module sync_capture_ctrl #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 2,
    parameter int SEL_W  = 1,
    parameter int CNT_W  = 18,
    parameter int DLY_W  = 8
`ifdef SYNC_AUTO_TRIG_EN
    , parameter int AUTO_W = 16
`endif
) (
    input  logic                   CLK,
    input  logic                   nRESET,
    input  logic                   CLK_EN,
    input  logic [N_CH*DATA_W-1:0] DATA_IN,
    input  logic [SEL_W-1:0]       Sync_channel_sel,
    input  logic [DATA_W-1:0]      Trg_Lv_UP,
    input  logic [DATA_W-1:0]      Trg_Lv_DOWN,
    input  logic [1:0]             Trig_Mode,
    input  logic [DLY_W-1:0]       Delay,
    input  logic                   sync_ON,
    input  logic                   Enable_Trig,
    input  logic                   LA_TRIGG_IN,
    input  logic                   LA_OR_OSC_TRIGG,
    input  logic [CNT_W-1:0]       PRE_CNT,
    input  logic [CNT_W-1:0]       WIN_DATA,
`ifdef SYNC_AUTO_TRIG_EN
    input  logic [AUTO_W-1:0]      Auto_Timeout,
    output logic                   Auto_Fired,
`endif
    sync_capture_ctrl_if.slave     mcu
);
    typedef enum logic [2:0] {S_IDLE, S_PRETRIG, S_ARMED, S_POST, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sel_sample;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              la_q, la_d;
    logic              hyst_q, hyst_d;
    logic [DLY_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  pre_q, pre_d;
    logic [CNT_W-1:0]  post_q, post_d;
    logic [CNT_W-1:0]  trig_pos_q, trig_pos_d;
    logic              raw_cond, qual, hyst_set, fire;
`ifdef SYNC_AUTO_TRIG_EN
    logic [AUTO_W-1:0] to_q, to_d;
    logic              auto_q, auto_d;
`endif

    always_comb begin
        sel_sample = DATA_IN[DATA_W-1:0];
        for (int k = 0; k < N_CH; k++) begin
            if (Sync_channel_sel == SEL_W'(k)) sel_sample = DATA_IN[k*DATA_W +: DATA_W];
        end
    end

    // Trigger condition is judged on the registered sample, one CLK_EN behind DATA_IN.
    always_comb begin
        raw_cond = 1'b0;
        case (Trig_Mode)
            2'd0:    raw_cond = hyst_q && (sample_q >= Trg_Lv_UP);
            2'd1:    raw_cond = hyst_q && (sample_q <= Trg_Lv_DOWN);
            2'd2:    raw_cond = (sample_q > Trg_Lv_UP) || (sample_q < Trg_Lv_DOWN);
            default: raw_cond = (sample_q >= Trg_Lv_DOWN) && (sample_q <= Trg_Lv_UP);
        endcase
        hyst_set = ((Trig_Mode == 2'd0) && (sample_q < Trg_Lv_DOWN)) ||
                   ((Trig_Mode == 2'd1) && (sample_q > Trg_Lv_UP));
        qual     = LA_OR_OSC_TRIGG ? la_q : raw_cond;
    end

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        la_d       = la_q;
        hyst_d     = (state_q == S_ARMED) ? hyst_q : 1'b0;
        run_d      = (state_q == S_ARMED) ? run_q : '0;
        idx_d      = idx_q;
        pre_d      = pre_q;
        post_d     = post_q;
        trig_pos_d = trig_pos_q;
        fire       = 1'b0;
`ifdef SYNC_AUTO_TRIG_EN
        to_d       = (state_q == S_ARMED) ? to_q : '0;
        auto_d     = (state_q == S_IDLE) ? 1'b0 : auto_q;
`endif
        if (CLK_EN) begin
            sample_d = sel_sample;
            la_d     = LA_TRIGG_IN;
        end

        if (!mcu.Start_Write) begin
            // Abort takes effect on the next CLK edge, independent of CLK_EN.
            state_d = S_IDLE;
            idx_d   = '0;
            pre_d   = '0;
            post_d  = '0;
            hyst_d  = 1'b0;
            run_d   = '0;
`ifdef SYNC_AUTO_TRIG_EN
            to_d    = '0;
            auto_d  = 1'b0;
`endif
        end else if (CLK_EN) begin
            if ((state_q inside {S_PRETRIG, S_ARMED, S_POST}) && (idx_q != '1))
                idx_d = idx_q + 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_PRETRIG;
                    idx_d   = '0;
                    pre_d   = '0;
                end
                S_PRETRIG: begin
                    pre_d = pre_q + 1'b1;
                    if ((PRE_CNT == '0) || (pre_d == PRE_CNT)) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (qual) run_d = (run_q == '1) ? run_q : run_q + 1'b1;
                    else      run_d = '0;
                    if (hyst_set) hyst_d = 1'b1;
                    fire = !sync_ON || (Enable_Trig && qual && (run_q == Delay));
`ifdef SYNC_AUTO_TRIG_EN
                    // A genuine trigger in the same sample wins, leaving Auto_Fired low.
                    if (sync_ON) begin
                        to_d = (to_q == '1) ? to_q : to_q + 1'b1;
                        if (!fire && (Auto_Timeout != '0) && (to_d == Auto_Timeout)) begin
                            fire   = 1'b1;
                            auto_d = 1'b1;
                        end
                    end
`endif
                    if (fire) begin
                        state_d    = S_POST;
                        trig_pos_d = idx_q;
                        post_d     = '0;
                        hyst_d     = 1'b0;
                        run_d      = '0;
                    end
                end
                S_POST: begin
                    post_d = post_q + 1'b1;
                    if ((WIN_DATA == '0) || (post_d == WIN_DATA)) state_d = S_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= S_IDLE;
            sample_q   <= '0;
            la_q       <= 1'b0;
            hyst_q     <= 1'b0;
            run_q      <= '0;
            idx_q      <= '0;
            pre_q      <= '0;
            post_q     <= '0;
            trig_pos_q <= '0;
`ifdef SYNC_AUTO_TRIG_EN
            to_q       <= '0;
            auto_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            la_q       <= la_d;
            hyst_q     <= hyst_d;
            run_q      <= run_d;
            idx_q      <= idx_d;
            pre_q      <= pre_d;
            post_q     <= post_d;
            trig_pos_q <= trig_pos_d;
`ifdef SYNC_AUTO_TRIG_EN
            to_q       <= to_d;
            auto_q     <= auto_d;
`endif
        end
    end

    assign mcu.Write_Ready    = mcu.Start_Write && (state_q == S_DONE);
    assign mcu.sync_state_out = (state_q == S_ARMED);
    assign mcu.Busy           = (state_q inside {S_PRETRIG, S_ARMED, S_POST});
    assign mcu.Trig_Pos       = trig_pos_q;
`ifdef SYNC_AUTO_TRIG_EN
    assign Auto_Fired         = auto_q;
`endif
endmodule
